id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_reg.sv | 155 +++++++++++++++
 tb/tb_id_ex_reg.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline definitions: bit positions inside the packed ID_EX bus,
// RegDst encodings, fixed destination register indices and the destination
// decode used by both the ID/EX register and the EX stage.
package pipe_pkg;

    localparam int ID_EX_W     = 185;

    localparam int ALUFUN_HI   = 184;
    localparam int ALUFUN_LO   = 179;
    localparam int ALUSRC1_BIT = 178;
    localparam int ALUSRC2_BIT = 177;
    localparam int REGDST_HI   = 176;
    localparam int REGDST_LO   = 175;
    localparam int LUOUT_HI    = 174;
    localparam int LUOUT_LO    = 143;
    localparam int SHAMT_HI    = 142;
    localparam int SHAMT_LO    = 111;
    localparam int IMM_HI      = 110;
    localparam int IMM_LO      = 79;
    localparam int RD_HI       = 78;
    localparam int RD_LO       = 74;
    localparam int RS_HI       = 73;
    localparam int RS_LO       = 69;
    localparam int RT_HI       = 68;
    localparam int RT_LO       = 64;
    localparam int RSDATA_HI   = 63;
    localparam int RSDATA_LO   = 32;
    localparam int RTDATA_HI   = 31;
    localparam int RTDATA_LO   = 0;

    typedef enum logic [1:0] {
        REGDST_RT = 2'b00,
        REGDST_RD = 2'b01,
        REGDST_RA = 2'b10,
        REGDST_XP = 2'b11
    } regdst_e;

    // Link register for jal-style writes, exception-PC register for the 11 case
    localparam logic [4:0] REG_RA = 5'd31;
    localparam logic [4:0] REG_XP = 5'd26;

    function automatic logic [4:0] dest_reg(input logic [1:0] regdst,
                                            input logic [4:0] rd,
                                            input logic [4:0] rt);
        logic [4:0] d;
        case (regdst_e'(regdst))
            REGDST_RT: d = rt;
            REGDST_RD: d = rd;
            REGDST_RA: d = REG_RA;
            default:   d = REG_XP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: EX holds a valid load whose destination is a
// non-zero register read by the valid instruction sitting in ID.
module load_use_detect (
    input  logic       i_ex_valid,
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_dest,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    output logic       o_hazard
);

    logic w_rs_hit;
    logic w_rt_hit;

    // Source match against the pending load destination
    always_comb begin
        w_rs_hit = (i_ex_dest == i_id_rs);
        w_rt_hit = i_id_uses_rt && (i_ex_dest == i_id_rt);
        o_hazard = i_ex_valid && i_ex_memread && (i_ex_dest != 5'd0) &&
                   i_id_valid && (w_rs_hit || w_rt_hit);
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and
// downstream stall hold. Optional performance counters are built when
// ID_EX_PERF_EN is defined (StallCnt/BubbleCnt ports appear only then).
module id_ex_reg
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          ID_ALUFun,
    input  logic                ID_ALUSrc1,
    input  logic                ID_ALUSrc2,
    input  logic [1:0]          ID_RegDst,
    input  logic [31:0]         ID_Imm32,
    input  logic [31:0]         ID_Shamt32,
    input  logic [31:0]         ID_LuOut,
    input  logic [4:0]          ID_Rd,
    input  logic [4:0]          ID_Rs,
    input  logic [4:0]          ID_Rt,
    input  logic [31:0]         ID_RsData,
    input  logic [31:0]         ID_RtData,
    input  logic [31:0]         ID_PC4,
    input  logic                ID_MemRead,
    input  logic                ID_MemWrite,
    input  logic                ID_RegWrite,
    input  logic                ID_UsesRt,
    input  logic [1:0]          ID_MemToReg,
    input  logic                ID_Valid,
    input  logic                Flush,
    input  logic                StallIn,
    output logic [ID_EX_W-1:0]  ID_EX,
    output logic [31:0]         EX_PC4,
    output logic [1:0]          EX_MemToReg,
    output logic                EX_MemRead,
    output logic                EX_MemWrite,
    output logic                EX_RegWrite,
    output logic                EX_Valid,
    output logic                HazardStall
`ifdef ID_EX_PERF_EN
    ,
    output logic [CNT_W-1:0]    StallCnt,
    output logic [CNT_W-1:0]    BubbleCnt
`endif
);

    logic [ID_EX_W-1:0] r_id_ex;
    logic [31:0]        r_pc4;
    logic [1:0]         r_memtoreg;
    logic               r_memread;
    logic               r_memwrite;
    logic               r_regwrite;
    logic               r_valid;

    logic [ID_EX_W-1:0] w_load_bus;
    logic [4:0]         w_ex_dest;
    logic               w_hazard;
    logic               w_bubble;

    // Pack the decoded ID fields into the EX bus layout
    always_comb begin
        w_load_bus = '0;
        w_load_bus[ALUFUN_HI:ALUFUN_LO] = ID_ALUFun;
        w_load_bus[ALUSRC1_BIT]         = ID_ALUSrc1;
        w_load_bus[ALUSRC2_BIT]         = ID_ALUSrc2;
        w_load_bus[REGDST_HI:REGDST_LO] = ID_RegDst;
        w_load_bus[LUOUT_HI:LUOUT_LO]   = ID_LuOut;
        w_load_bus[SHAMT_HI:SHAMT_LO]   = ID_Shamt32;
        w_load_bus[IMM_HI:IMM_LO]       = ID_Imm32;
        w_load_bus[RD_HI:RD_LO]         = ID_Rd;
        w_load_bus[RS_HI:RS_LO]         = ID_Rs;
        w_load_bus[RT_HI:RT_LO]         = ID_Rt;
        w_load_bus[RSDATA_HI:RSDATA_LO] = ID_RsData;
        w_load_bus[RTDATA_HI:RTDATA_LO] = ID_RtData;
    end

    assign w_ex_dest = dest_reg(r_id_ex[REGDST_HI:REGDST_LO],
                                r_id_ex[RD_HI:RD_LO],
                                r_id_ex[RT_HI:RT_LO]);

    load_use_detect u_load_use_detect (
        .i_ex_valid   (r_valid),
        .i_ex_memread (r_memread),
        .i_ex_dest    (w_ex_dest),
        .i_id_valid   (ID_Valid),
        .i_id_rs      (ID_Rs),
        .i_id_rt      (ID_Rt),
        .i_id_uses_rt (ID_UsesRt),
        .o_hazard     (w_hazard)
    );

    // A flush always bubbles; a load-use bubble is suppressed while held
    assign w_bubble = Flush || (!StallIn && w_hazard);

    // Pipeline register: reset > flush > hold > load-use bubble > load
    always_ff @(posedge clk) begin
        if (!rst_n || w_bubble) begin
            r_id_ex    <= '0;
            r_pc4      <= '0;
            r_memtoreg <= '0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_regwrite <= 1'b0;
            r_valid    <= 1'b0;
        end else if (!StallIn) begin
            r_id_ex    <= w_load_bus;
            r_pc4      <= ID_PC4;
            r_memtoreg <= ID_MemToReg;
            r_memread  <= ID_MemRead  && ID_Valid;
            r_memwrite <= ID_MemWrite && ID_Valid;
            r_regwrite <= ID_RegWrite && ID_Valid;
            r_valid    <= ID_Valid;
        end
    end

    assign ID_EX       = r_id_ex;
    assign EX_PC4      = r_pc4;
    assign EX_MemToReg = r_memtoreg;
    assign EX_MemRead  = r_memread;
    assign EX_MemWrite = r_memwrite;
    assign EX_RegWrite = r_regwrite;
    assign EX_Valid    = r_valid;
    assign HazardStall = w_hazard;

`ifdef ID_EX_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_stall_evt;

    // A hazard coinciding with a flush is accounted as a flush only
    assign w_stall_evt = w_hazard && !StallIn && !Flush;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_bubble && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
        end
    end

    assign StallCnt  = r_stall_cnt;
    assign BubbleCnt = r_bubble_cnt;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

    logic         clk;
    logic         rst_n;
    logic [5:0]   ID_ALUFun;
    logic         ID_ALUSrc1, ID_ALUSrc2;
    logic [1:0]   ID_RegDst;
    logic [31:0]  ID_Imm32, ID_Shamt32, ID_LuOut;
    logic [4:0]   ID_Rd, ID_Rs, ID_Rt;
    logic [31:0]  ID_RsData, ID_RtData, ID_PC4;
    logic         ID_MemRead, ID_MemWrite, ID_RegWrite, ID_UsesRt;
    logic [1:0]   ID_MemToReg;
    logic         ID_Valid, Flush, StallIn;
    logic [184:0] ID_EX;
    logic [31:0]  EX_PC4;
    logic [1:0]   EX_MemToReg;
    logic         EX_MemRead, EX_MemWrite, EX_RegWrite, EX_Valid, HazardStall;
    logic [3:0]   StallCnt, BubbleCnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [184:0] bus;
        logic [31:0]  pc4;
        logic [1:0]   m2r;
        logic         mr, mw, rw, v;
        logic [3:0]   sc, bc;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    id_ex_reg #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_ALUFun(ID_ALUFun), .ID_ALUSrc1(ID_ALUSrc1), .ID_ALUSrc2(ID_ALUSrc2),
        .ID_RegDst(ID_RegDst), .ID_Imm32(ID_Imm32), .ID_Shamt32(ID_Shamt32),
        .ID_LuOut(ID_LuOut), .ID_Rd(ID_Rd), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_PC4(ID_PC4),
        .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite), .ID_RegWrite(ID_RegWrite),
        .ID_UsesRt(ID_UsesRt), .ID_MemToReg(ID_MemToReg), .ID_Valid(ID_Valid),
        .Flush(Flush), .StallIn(StallIn),
        .ID_EX(ID_EX), .EX_PC4(EX_PC4), .EX_MemToReg(EX_MemToReg),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_RegWrite(EX_RegWrite),
        .EX_Valid(EX_Valid), .HazardStall(HazardStall)
`ifdef ID_EX_PERF_EN
        , .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
`endif
    );

`ifndef ID_EX_PERF_EN
    assign StallCnt  = 4'h0;
    assign BubbleCnt = 4'h0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [184:0] obs, input logic [184:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [5:0] fun, input logic [1:0] rdst,
                             input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [31:0] imm, input logic mr, input logic mw,
                             input logic rw, input logic ur, input logic v);
        ID_ALUFun   = fun;
        ID_ALUSrc1  = rs[0];
        ID_ALUSrc2  = rt[0];
        ID_RegDst   = rdst;
        ID_Imm32    = imm;
        ID_Shamt32  = imm ^ 32'hA5A5_5A5A;
        ID_LuOut    = {imm[15:0], 16'h0000};
        ID_Rd       = rd;
        ID_Rs       = rs;
        ID_Rt       = rt;
        ID_RsData   = imm + 32'h1111_0000;
        ID_RtData   = ~imm;
        ID_PC4      = 32'h0040_0000 + imm;
        ID_MemRead  = mr;
        ID_MemWrite = mw;
        ID_RegWrite = rw;
        ID_UsesRt   = ur;
        ID_MemToReg = rd[1:0];
        ID_Valid    = v;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        total++;
        assert (q.size() > 0) else begin
            bad++;
            $error("FAIL %s:queue observed=empty expected=entry", tag);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, ":bus"}, ID_EX, e.bus);
            chk({tag, ":pc4"}, {153'd0, EX_PC4}, {153'd0, e.pc4});
            chk({tag, ":ctl"}, {178'd0, EX_MemToReg, EX_MemRead, EX_MemWrite, EX_RegWrite, EX_Valid},
                               {178'd0, e.m2r, e.mr, e.mw, e.rw, e.v});
`ifdef ID_EX_PERF_EN
            chk({tag, ":cnt"}, {177'd0, StallCnt, BubbleCnt}, {177'd0, e.sc, e.bc});
`endif
        end
    endtask

    // One clock: drive controls, check combinational hazard, predict and compare
    task automatic cycle(input logic flush, input logic stall, input logic exp_hz, input string tag);
        exp_t nx;
        @(negedge clk);
        Flush   = flush;
        StallIn = stall;
        #1;
        chk({tag, ":hz"}, {184'd0, HazardStall}, {184'd0, exp_hz});
        nx = cur;
        if (flush || (!stall && exp_hz)) begin
            nx.bus = '0; nx.pc4 = '0; nx.m2r = '0;
            nx.mr = 1'b0; nx.mw = 1'b0; nx.rw = 1'b0; nx.v = 1'b0;
            if (cur.bc != 4'hF) nx.bc = cur.bc + 4'h1;
            if (!flush && cur.sc != 4'hF) nx.sc = cur.sc + 4'h1;
        end else if (!stall) begin
            nx.bus = {ID_ALUFun, ID_ALUSrc1, ID_ALUSrc2, ID_RegDst, ID_LuOut, ID_Shamt32,
                      ID_Imm32, ID_Rd, ID_Rs, ID_Rt, ID_RsData, ID_RtData};
            nx.pc4 = ID_PC4;
            nx.m2r = ID_MemToReg;
            nx.mr  = ID_MemRead  & ID_Valid;
            nx.mw  = ID_MemWrite & ID_Valid;
            nx.rw  = ID_RegWrite & ID_Valid;
            nx.v   = ID_Valid;
        end
        q.push_back(nx);
        cur = nx;
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic reset_cycle(input logic flush, input logic stall, input string tag);
        @(negedge clk);
        rst_n   = 1'b0;
        Flush   = flush;
        StallIn = stall;
        cur = '0;
        q.push_back(cur);
        @(posedge clk);
        #1;
        check_out(tag);
        chk({tag, ":hz"}, {184'd0, HazardStall}, 185'd0);
        rst_n   = 1'b1;
        Flush   = 1'b0;
        StallIn = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; Flush = 1'b0; StallIn = 1'b0;
        cur = '0;
        set_instr(6'h3F, 2'b01, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        reset_cycle(1'b0, 1'b0, "reset");

        // basic load
        set_instr(6'h01, 2'b01, 5'd5, 5'd3, 5'd4, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, "load_basic");
        chk("basic_fun", {179'd0, ID_EX[184:179]}, {179'd0, 6'h01});
        chk("basic_rs",  {180'd0, ID_EX[73:69]},   {180'd0, 5'd3});
        chk("basic_imm", {153'd0, ID_EX[110:79]},  {153'd0, 32'h10});
        chk("basic_v",   {184'd0, EX_Valid},       {184'd0, 1'b1});

        // lw to Rt=8, then consumer of Rs=8
        set_instr(6'h20, 2'b00, 5'd0, 5'd2, 5'd8, 32'h4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, "lw_rt8");
        set_instr(6'h02, 2'b01, 5'd9, 5'd8, 5'd10, 32'h5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, "lu_rs");
        chk("lu_bubble_v",  {184'd0, EX_Valid},    185'd0);
        chk("lu_bubble_hz", {184'd0, HazardStall}, 185'd0);
`ifdef ID_EX_PERF_EN
        chk("lu_bubble_cnt", {181'd0, BubbleCnt}, {181'd0, 4'h1});
`endif
        cycle(1'b0, 1'b0, 1'b0, "lu_retry");

        // dest 0 never stalls; Rt match ignored when Rt is not a source
        set_instr(6'h20, 2'b00, 5'd0, 5'd1, 5'd0, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, "lw_rt0");
        set_instr(6'h20, 2'b00, 5'd0, 5'd0, 5'd7, 32'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, "dest0");
        set_instr(6'h03, 2'b01, 5'd11, 5'd1, 5'd7, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, "no_uses_rt");

        // RegDst 10 -> r31, 11 -> r26, 01 -> Rd
        set_instr(6'h20, 2'b10, 5'd0, 5'd1, 5'd2, 32'h14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, "lw_r31");
        set_instr(6'h04, 2'b01, 5'd3, 5'd31, 5'd1, 32'h18, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, "lu_r31");
        set_instr(6'h20, 2'b11, 5'd0, 5'd1, 5'd2, 32'h1C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, "lw_r26");
        set_instr(6'h05, 2'b01, 5'd4, 5'd1, 5'd26, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, "lu_r26_rt");
        set_instr(6'h20, 2'b01, 5'd12, 5'd1, 5'd2, 32'h24, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, "lw_rd12");

        // invalid ID: no hazard, controls forced low when loaded
        set_instr(6'h06, 2'b01, 5'd5, 5'd12, 5'd1, 32'h28, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, "id_invalid");

        // flush + stall together, flush + hazard together
        set_instr(6'h20, 2'b00, 5'd0, 5'd1, 5'd8, 32'h2C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, "lw_a");
        set_instr(6'h07, 2'b01, 5'd6, 5'd8, 5'd1, 32'h30, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, "flush_stall");
        set_instr(6'h20, 2'b00, 5'd0, 5'd1, 5'd8, 32'h34, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, "lw_b");
        set_instr(6'h08, 2'b01, 5'd7, 5'd8, 5'd1, 32'h38, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, "flush_hz");

        // hold for 3 cycles with hazard visible from held load
        set_instr(6'h20, 2'b00, 5'd0, 5'd1, 5'd8, 32'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, "lw_c");
        for (int i = 0; i < 3; i++) begin
            set_instr(6'h09 + 6'(i), 2'b01, 5'(i + 2), 5'd8, 5'(i), 32'h100 + 32'(i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            cycle(1'b0, 1'b1, 1'b1, "hold");
        end
        cycle(1'b0, 1'b0, 1'b1, "hold_release");

        // reset overrides a stall holding valid contents
        set_instr(6'h11, 2'b01, 5'd13, 5'd2, 5'd3, 32'h3C0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, "pre_reset");
        reset_cycle(1'b1, 1'b1, "reset_mid_stall");

        // 20 load-use stalls to saturate the 4-bit counters
        for (int i = 0; i < 20; i++) begin
            set_instr(6'h20, 2'b00, 5'd0, 5'd1, 5'd8, 32'(i * 4), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0, "sat_lw");
            set_instr(6'h12, 2'b01, 5'd9, 5'd8, 5'd2, 32'(i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            cycle(1'b0, 1'b0, 1'b1, "sat_use");
        end
`ifdef ID_EX_PERF_EN
        chk("stall_sat", {181'd0, StallCnt}, {181'd0, 4'hF});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
